bus_condition_monitor: RTL and testbench

- Observes the synchronized SCL/SDA lines of the active controller.
- Detects START, repeated START and STOP; tracks bus busy state.
- Times how long the bus has been continuously high, against programmable Bus Free, Bus Available and Bus Idle thresholds.
- Sits directly upstream of controller_active: its outputs gate when the flow FSM may arbitrate for, or start driving, the bus.

---
 rtl/controller_pkg.sv | 12 +
 rtl/bus_timer.sv | 24 ++
 rtl/bus_condition_monitor.sv | 109 ++++++++++
 tb/tb_bus_condition_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared types and widths for the bus controller: bus state encoding and the
// width of the high-time counter and the t_bus_* threshold fields.
package controller_pkg;

    localparam int BusCntWidth = 20;

    typedef enum logic {
        BusIdle = 1'b0,
        BusBusy = 1'b1
    } bus_state_e;

endpackage

// File: rtl/bus_timer.sv
// Saturating up-counter for bus high time; clear has priority over increment.
import controller_pkg::*;

module bus_timer #(
    parameter int CntWidth = BusCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                inc_i,
    output logic [CntWidth-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clear_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CntWidth'(1);
        end
    end

endmodule

// File: rtl/bus_condition_monitor.sv
// Watches synchronized SCL/SDA for START/repeated START/STOP, tracks bus busy
// and times continuous bus-high against Bus Free/Available/Idle thresholds.
import controller_pkg::*;

module bus_condition_monitor #(
    parameter int CntWidth = BusCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                scl_i,
    input  logic                sda_i,
    input  logic [CntWidth-1:0] t_bus_free_i,
    input  logic [CntWidth-1:0] t_bus_available_i,
    input  logic [CntWidth-1:0] t_bus_idle_i,
    output logic                start_det_o,
    output logic                rstart_det_o,
    output logic                stop_det_o,
    output logic                bus_busy_o,
    output logic                bus_free_o,
    output logic                bus_available_o,
    output logic                bus_idle_o,
    output logic [CntWidth-1:0] high_cnt_o
);

    logic       scl_q;
    logic       sda_q;
    logic       start_cond;
    logic       stop_cond;
    logic       cnt_clear;
    bus_state_e state_q;
    bus_state_e state_d;

    logic [CntWidth-1:0] teff_free;
    logic [CntWidth-1:0] teff_available;
    logic [CntWidth-1:0] teff_idle;

    // Line samples run even when disabled so re-enabling never sees a stale edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
        end
    end

    assign start_cond = scl_q & scl_i & sda_q & ~sda_i;
    assign stop_cond  = scl_q & scl_i & ~sda_q & sda_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BusIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = BusIdle;
        end else begin
            unique case (state_q)
                BusIdle: if (start_cond) state_d = BusBusy;
                BusBusy: if (stop_cond)  state_d = BusIdle;
                default: state_d = BusIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_det_o  <= 1'b0;
            rstart_det_o <= 1'b0;
            stop_det_o   <= 1'b0;
        end else begin
            start_det_o  <= enable_i & start_cond & (state_q == BusIdle);
            rstart_det_o <= enable_i & start_cond & (state_q == BusBusy);
            stop_det_o   <= enable_i & stop_cond;
        end
    end

    assign bus_busy_o = (state_q == BusBusy);

    // The sample that completes a STOP already counts as the first high cycle.
    assign cnt_clear = ~enable_i | ~scl_i | ~sda_i | (state_d == BusBusy);

    bus_timer #(
        .CntWidth (CntWidth)
    ) u_bus_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (cnt_clear),
        .inc_i   (1'b1),
        .cnt_o   (high_cnt_o)
    );

    // A zero threshold behaves as one so no flag can be set straight out of reset.
    assign teff_free      = (t_bus_free_i == '0)      ? CntWidth'(1) : t_bus_free_i;
    assign teff_available = (t_bus_available_i == '0) ? CntWidth'(1) : t_bus_available_i;
    assign teff_idle      = (t_bus_idle_i == '0)      ? CntWidth'(1) : t_bus_idle_i;

    assign bus_free_o      = enable_i & ~bus_busy_o & (high_cnt_o >= teff_free);
    assign bus_available_o = enable_i & ~bus_busy_o & (high_cnt_o >= teff_available);
    assign bus_idle_o      = enable_i & ~bus_busy_o & (high_cnt_o >= teff_idle);

endmodule

// File: tb/tb_bus_condition_monitor.sv
// Directed bench for bus_condition_monitor: a vector table for edge detection
// and busy tracking, plus sequences for thresholds, glitches and reset.
module tb_bus_condition_monitor;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         scl;
    logic         sda;
    logic [W-1:0] t_free;
    logic [W-1:0] t_avail;
    logic [W-1:0] t_idle;
    logic         start_det;
    logic         rstart_det;
    logic         stop_det;
    logic         bus_busy;
    logic         bus_free;
    logic         bus_available;
    logic         bus_idle;
    logic [W-1:0] high_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bus_condition_monitor #(.CntWidth(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .scl_i             (scl),
        .sda_i             (sda),
        .t_bus_free_i      (t_free),
        .t_bus_available_i (t_avail),
        .t_bus_idle_i      (t_idle),
        .start_det_o       (start_det),
        .rstart_det_o      (rstart_det),
        .stop_det_o        (stop_det),
        .bus_busy_o        (bus_busy),
        .bus_free_o        (bus_free),
        .bus_available_o   (bus_available),
        .bus_idle_o        (bus_idle),
        .high_cnt_o        (high_cnt)
    );

    // {start, rstart, stop, busy, idle, avail, free, cnt}
    logic [26:0] obs;
    assign obs = {start_det, rstart_det, stop_det, bus_busy,
                  bus_idle, bus_available, bus_free, high_cnt};

    // {en, scl, sda | start, rstart, stop, busy | idle, avail, free | cnt}
    typedef struct packed {
        logic [2:0]   in;
        logic [3:0]   pulses;
        logic [2:0]   flags;
        logic [W-1:0] cnt;
    } vec_t;

    vec_t tbl [30];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic s_cl, input logic s_da);
        enable = en;
        scl    = s_cl;
        sda    = s_da;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = {3'b111, 4'b0000, 3'b000, 20'd1};
        tbl[1]  = {3'b111, 4'b0000, 3'b001, 20'd2};
        tbl[2]  = {3'b111, 4'b0000, 3'b011, 20'd3};
        tbl[3]  = {3'b110, 4'b1001, 3'b000, 20'd0};
        tbl[4]  = {3'b100, 4'b0001, 3'b000, 20'd0};
        tbl[5]  = {3'b101, 4'b0001, 3'b000, 20'd0};
        tbl[6]  = {3'b111, 4'b0001, 3'b000, 20'd0};
        tbl[7]  = {3'b110, 4'b0101, 3'b000, 20'd0};
        tbl[8]  = {3'b111, 4'b0010, 3'b000, 20'd1};
        tbl[9]  = {3'b111, 4'b0000, 3'b001, 20'd2};
        tbl[10] = {3'b110, 4'b1001, 3'b000, 20'd0};
        tbl[11] = {3'b111, 4'b0010, 3'b000, 20'd1};
        tbl[12] = {3'b110, 4'b1001, 3'b000, 20'd0};
        tbl[13] = {3'b101, 4'b0001, 3'b000, 20'd0};
        tbl[14] = {3'b110, 4'b0001, 3'b000, 20'd0};
        tbl[15] = {3'b111, 4'b0010, 3'b000, 20'd1};
        tbl[16] = {3'b100, 4'b0000, 3'b000, 20'd0};
        tbl[17] = {3'b111, 4'b0000, 3'b000, 20'd1};
        tbl[18] = {3'b111, 4'b0000, 3'b001, 20'd2};
        tbl[19] = {3'b110, 4'b1001, 3'b000, 20'd0};
        tbl[20] = {3'b011, 4'b0000, 3'b000, 20'd0};
        tbl[21] = {3'b011, 4'b0000, 3'b000, 20'd0};
        tbl[22] = {3'b111, 4'b0000, 3'b000, 20'd1};
        tbl[23] = {3'b111, 4'b0000, 3'b001, 20'd2};
        tbl[24] = {3'b111, 4'b0000, 3'b011, 20'd3};
        tbl[25] = {3'b111, 4'b0000, 3'b011, 20'd4};
        tbl[26] = {3'b111, 4'b0000, 3'b111, 20'd5};
        tbl[27] = {3'b110, 4'b1001, 3'b000, 20'd0};
        tbl[28] = {3'b010, 4'b0000, 3'b000, 20'd0};
        tbl[29] = {3'b111, 4'b0010, 3'b000, 20'd1};

        // Reset state, zero thresholds treated as one
        rst     = 1'b1;
        t_free  = '0;
        t_avail = '0;
        t_idle  = '0;
        drive(1'b1, 1'b1, 1'b1);
        #2;
        check("reset_outputs", 64'(obs), 64'd0);
        #10;
        rst = 1'b0;
        step();
        check("zero_thr_first_sample", 64'(obs), 64'({4'b0000, 3'b111, 20'd1}));
        step();
        step();
        check("zero_thr_cnt3", 64'(high_cnt), 64'd3);

        // Asynchronous reset mid-count, away from any clock edge
        rst = 1'b1;
        #2;
        check("async_reset_outputs", 64'(obs), 64'd0);
        rst = 1'b0;

        // Long high run against 10/50/200 thresholds
        do_reset();
        t_free  = 20'd10;
        t_avail = 20'd50;
        t_idle  = 20'd200;
        for (int n = 1; n <= 200; n++) begin
            step();
            if (n == 9 || n == 10 || n == 49 || n == 50 || n == 199 || n == 200) begin
                check($sformatf("long_run_n%0d", n),
                      64'({bus_idle, bus_available, bus_free, high_cnt}),
                      64'({n >= 200, n >= 50, n >= 10, 20'(n)}));
            end
        end
        t_free = 20'd300;
        #1;
        check("thr_change_immediate", 64'({bus_available, bus_free, high_cnt}),
              64'({1'b1, 1'b0, 20'd200}));

        // Edge detection / busy table with thresholds 2/3/5
        do_reset();
        t_free  = 20'd2;
        t_avail = 20'd3;
        t_idle  = 20'd5;
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            step();
            check($sformatf("vec%0d", i), 64'(obs),
                  64'({tbl[i].pulses, tbl[i].flags, tbl[i].cnt}));
        end

        // STOP, then SDA glitch during the bus-free count
        t_free  = 20'd4;
        t_avail = 20'd100;
        t_idle  = 20'd100;
        drive(1'b1, 1'b1, 1'b0);
        step();
        check("glitch_start", 64'({start_det, bus_busy}), 64'(2'b11));
        drive(1'b1, 1'b1, 1'b1);
        step();
        check("glitch_stop", 64'({stop_det, bus_busy, bus_free, high_cnt}),
              64'({3'b100, 20'd1}));
        step();
        check("glitch_cnt2", 64'({bus_free, high_cnt}), 64'({1'b0, 20'd2}));
        drive(1'b1, 1'b1, 1'b0);
        step();
        check("glitch_low", 64'({bus_busy, bus_free, high_cnt}), 64'({2'b10, 20'd0}));
        drive(1'b1, 1'b1, 1'b1);
        step();
        check("glitch_restop", 64'({stop_det, bus_free, high_cnt}), 64'({2'b10, 20'd1}));
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("glitch_free_k%0d", k), 64'({bus_free, high_cnt}),
                  64'({k >= 4, 20'(k)}));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
